// File: rtl/debug_transport.sv
// JTAG-style DTM front end: dtmcs/dmi scan registers driving single-cycle DM register accesses.
// Optional DEBUG_TRANSPORT_HARDRESET_EN adds dtmcs.dtmhardreset (bit 17) to abort and clear transport state.
module debug_transport #(
  parameter int unsigned IDLE_CYCLES = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iSelDtmcs,
  input  logic        iCapture,
  input  logic        iShift,
  input  logic        iUpdate,
  input  logic        iTdi,
  output logic        oTdo,
  output logic [7:0]  oDmAddr,
  output logic [31:0] oDmWdata,
  output logic        oDmWrite,
  output logic        oDmRead,
  input  logic [31:0] iDmRdata,
  output logic        oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;

  localparam logic [2:0] IDLE_CNT = 3'(IDLE_CYCLES);

  state_t      r_state;
  logic [2:0]  r_idle_cnt;
  logic [40:0] r_shreg;
  logic [6:0]  r_req_addr;
  logic [31:0] r_req_data;
  logic [1:0]  r_req_op;
  logic [31:0] r_resp_data;
  logic [1:0]  r_dmistat;
  logic        r_dm_read;
  logic        r_dm_write;

  logic        w_busy;
  logic [31:0] w_dtmcs;
  logic [1:0]  w_status;
  logic        w_hardreset;

  assign w_busy   = (r_state != S_IDLE);
  assign w_dtmcs  = {17'd0, IDLE_CNT, r_dmistat, 6'd7, 4'd1};
  assign w_status = (w_busy || r_dmistat == 2'd3) ? 2'd3 : r_dmistat;

`ifdef DEBUG_TRANSPORT_HARDRESET_EN
  assign w_hardreset = iUpdate && iSelDtmcs && r_shreg[17];
`else
  assign w_hardreset = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_idle_cnt  <= 3'd0;
      r_shreg     <= 41'd0;
      r_req_addr  <= 7'd0;
      r_req_data  <= 32'd0;
      r_req_op    <= 2'd0;
      r_resp_data <= 32'd0;
      r_dmistat   <= 2'd0;
      r_dm_read   <= 1'b0;
      r_dm_write  <= 1'b0;
    end else begin
      r_dm_read  <= 1'b0;
      r_dm_write <= 1'b0;

      case (r_state)
        S_ACCESS: begin
          if (r_req_op == 2'd1) r_resp_data <= iDmRdata;
          if (IDLE_CNT != 3'd0) begin
            r_state    <= S_HOLD;
            r_idle_cnt <= IDLE_CNT - 3'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (r_idle_cnt == 3'd0) r_state <= S_IDLE;
          else                    r_idle_cnt <= r_idle_cnt - 3'd1;
        end
        default: ;
      endcase

      // Only the highest-priority strobe acts: update, then capture, then shift.
      if (iUpdate) begin
        if (iSelDtmcs) begin
          if (r_shreg[16]) r_dmistat <= 2'd0;
          if (w_hardreset) begin
            r_dmistat   <= 2'd0;
            r_resp_data <= 32'd0;
            r_req_addr  <= 7'd0;
            r_req_data  <= 32'd0;
            r_req_op    <= 2'd0;
            r_idle_cnt  <= 3'd0;
            r_state     <= S_IDLE;
          end
        end else if (r_dmistat == 2'd0) begin
          if (w_busy) begin
            r_dmistat <= 2'd3;
          end else if (r_shreg[1:0] == 2'd1 || r_shreg[1:0] == 2'd2) begin
            r_req_addr <= r_shreg[40:34];
            r_req_data <= r_shreg[33:2];
            r_req_op   <= r_shreg[1:0];
            r_state    <= S_ACCESS;
            r_dm_read  <= (r_shreg[1:0] == 2'd1);
            r_dm_write <= (r_shreg[1:0] == 2'd2);
          end
        end
      end else if (iCapture) begin
        if (iSelDtmcs) begin
          r_shreg <= {9'd0, w_dtmcs};
        end else begin
          r_shreg <= {r_req_addr, r_resp_data, w_status};
          if (w_busy) r_dmistat <= 2'd3;
        end
      end else if (iShift) begin
        if (iSelDtmcs) r_shreg[31:0] <= {iTdi, r_shreg[31:1]};
        else           r_shreg       <= {iTdi, r_shreg[40:1]};
      end
    end
  end

  assign oTdo     = r_shreg[0];
  assign oDmAddr  = {1'b0, r_req_addr};
  assign oDmWdata = r_req_data;
  assign oDmRead  = r_dm_read;
  assign oDmWrite = r_dm_write;
  assign oBusy    = w_busy;

endmodule
